// File: rtl/pipeline_controller.sv
// -----------------------------------------------------------------------------
// pipeline_controller
//   Central hazard/flush controller for a 5-stage in-order pipeline.
//   Combines stall requests from ID/EX/MEM into a per-latch hold vector,
//   accepts MEM-stage exceptions, and converts memory stalls that never
//   complete into a bus-error flush.
//
// Parameters
//   TIMEOUT_CYCLES   consecutive memory-stall cycles before a bus-error flush
//   BUS_ERROR_VECTOR PC loaded on a bus-error flush
//
// Ports
//   clock                      in   single clock, rising edge
//   reset                      in   asynchronous, active-low
//   id_stall_request           in   load-use hazard from decode
//   ex_stall_request           in   multi-cycle execute busy
//   mem_stall_request          in   memory access outstanding
//   exception_request          in   exception raised in MEM (level)
//   exception_handler_address  in   handler PC for exception_request
//   counter_clear              in   synchronous clear of stall_count
//   stall[5:0]                 out  hold per latch: PC, IF/ID, ID/EX, EX/MEM, MEM/WB, WB
//   flush                      out  clear every pipeline latch (registered)
//   flush_address[31:0]        out  PC loaded while flush=1 (registered)
//   bus_error                  out  one-cycle pulse on memory timeout (registered)
//   stall_count[15:0]          out  saturating count of stalled cycles (registered)
// -----------------------------------------------------------------------------
module pipeline_controller #(
  parameter int unsigned TIMEOUT_CYCLES   = 256,
  parameter logic [31:0] BUS_ERROR_VECTOR = 32'h00000180
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_stall_request,
  input  logic        ex_stall_request,
  input  logic        mem_stall_request,
  input  logic        exception_request,
  input  logic [31:0] exception_handler_address,
  input  logic        counter_clear,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] flush_address,
  output logic        bus_error,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_timeout_cnt;
  logic        r_flush;
  logic        r_bus_error;
  logic [31:0] r_flush_address;
  logic [15:0] r_stall_count;
  logic [5:0]  w_stall;
  logic        w_timeout;
  logic        w_exc_take;

  // The counter already holds TIMEOUT_CYCLES-1 earlier stalled cycles, so this
  // cycle is the last one allowed before the access is declared dead.
  assign w_timeout  = (r_state == ST_RUN) && mem_stall_request &&
                      (r_timeout_cnt == TIMEOUT_LAST);
  // An exception must wait for the memory access to finish; a pending
  // timeout therefore always wins because it requires mem_stall_request=1.
  assign w_exc_take = (r_state == ST_RUN) && exception_request && !mem_stall_request;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: FLUSH and RECOVER are single-cycle states.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_timeout || w_exc_take) begin
          w_next_state = ST_FLUSH;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_FLUSH:   w_next_state = ST_RECOVER;
      ST_RECOVER: w_next_state = ST_RUN;
      default:    w_next_state = ST_RUN;
    endcase
  end

  // Stall vector: priority mem > ex > id, only while running and out of reset.
  always_comb begin
    w_stall = STALL_NONE;
    if (reset && (r_state == ST_RUN)) begin
      if (mem_stall_request) begin
        w_stall = STALL_MEM;
      end else if (ex_stall_request) begin
        w_stall = STALL_EX;
      end else if (id_stall_request) begin
        w_stall = STALL_ID;
      end else begin
        w_stall = STALL_NONE;
      end
    end else begin
      w_stall = STALL_NONE;
    end
  end

  // Memory timeout counter: counts consecutive stalled RUN cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_timeout_cnt <= 16'd0;
    end else if ((r_state == ST_RUN) && mem_stall_request && !w_timeout) begin
      r_timeout_cnt <= r_timeout_cnt + 16'd1;
    end else begin
      r_timeout_cnt <= 16'd0;
    end
  end

  // Flush, bus-error and flush target registers, loaded on flush entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_flush         <= 1'b0;
      r_bus_error     <= 1'b0;
      r_flush_address <= 32'h0000_0000;
    end else begin
      r_flush     <= (w_next_state == ST_FLUSH);
      r_bus_error <= w_timeout;
      if (w_timeout) begin
        r_flush_address <= BUS_ERROR_VECTOR;
      end else if (w_exc_take) begin
        r_flush_address <= exception_handler_address;
      end else begin
        r_flush_address <= r_flush_address;
      end
    end
  end

  // Saturating stall-cycle counter; clear has priority over increment.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_count <= 16'd0;
    end else if (counter_clear) begin
      r_stall_count <= 16'd0;
    end else if ((w_stall != STALL_NONE) && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end else begin
      r_stall_count <= r_stall_count;
    end
  end

  assign stall         = w_stall;
  assign flush         = r_flush;
  assign flush_address = r_flush_address;
  assign bus_error     = r_bus_error;
  assign stall_count   = r_stall_count;

endmodule

// File: tb/tb_pipeline_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_controller
//   Directed stimulus against pipeline_controller (TIMEOUT_CYCLES=8) with a
//   behavioural reference model checked on every falling clock edge, plus
//   hand-computed literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_pipeline_controller;

  localparam int          TMO = 8;
  localparam logic [31:0] BEV = 32'h00000180;

  localparam int MODE_RUN     = 0;
  localparam int MODE_FLUSH   = 1;
  localparam int MODE_RECOVER = 2;

  logic        clock;
  logic        reset;
  logic        id_req;
  logic        ex_req;
  logic        mem_req;
  logic        exc_req;
  logic [31:0] exc_addr;
  logic        clr;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_address;
  logic        bus_error;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_controller #(
    .TIMEOUT_CYCLES   (TMO),
    .BUS_ERROR_VECTOR (BEV)
  ) dut (
    .clock                     (clock),
    .reset                     (reset),
    .id_stall_request          (id_req),
    .ex_stall_request          (ex_req),
    .mem_stall_request         (mem_req),
    .exception_request         (exc_req),
    .exception_handler_address (exc_addr),
    .counter_clear             (clr),
    .stall                     (stall),
    .flush                     (flush),
    .flush_address             (flush_address),
    .bus_error                 (bus_error),
    .stall_count               (stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_mode;
  int          m_mem_run;   // stalled memory cycles seen so far in this run
  int          m_count;
  logic [31:0] m_faddr;
  logic        m_berr;

  function automatic logic [5:0] exp_stall();
    if (!reset || m_mode != MODE_RUN) return 6'b000000;
    if (mem_req) return 6'b011111;
    if (ex_req)  return 6'b001111;
    if (id_req)  return 6'b000111;
    return 6'b000000;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_mode    <= MODE_RUN;
      m_mem_run <= 0;
      m_count   <= 0;
      m_faddr   <= 32'h0;
      m_berr    <= 1'b0;
    end else begin
      if (clr) m_count <= 0;
      else if (exp_stall() != 6'b000000 && m_count < 65535) m_count <= m_count + 1;
      m_berr <= 1'b0;
      if (m_mode == MODE_RUN) begin
        if (mem_req) begin
          if (m_mem_run + 1 == TMO) begin
            m_mode    <= MODE_FLUSH;
            m_faddr   <= BEV;
            m_berr    <= 1'b1;
            m_mem_run <= 0;
          end else begin
            m_mem_run <= m_mem_run + 1;
          end
        end else begin
          m_mem_run <= 0;
          if (exc_req) begin
            m_mode  <= MODE_FLUSH;
            m_faddr <= exc_addr;
          end
        end
      end else if (m_mode == MODE_FLUSH) begin
        m_mode    <= MODE_RECOVER;
        m_mem_run <= 0;
      end else begin
        m_mode    <= MODE_RUN;
        m_mem_run <= 0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    chk("stall",         {26'd0, stall},        {26'd0, exp_stall()});
    chk("flush",         {31'd0, flush},        {31'd0, (reset && m_mode == MODE_FLUSH)});
    chk("flush_address", flush_address,         m_faddr);
    chk("bus_error",     {31'd0, bus_error},    {31'd0, m_berr});
    chk("stall_count",   {16'd0, stall_count},  m_count);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic id, input logic ex, input logic mem, input logic exc,
                     input logic [31:0] addr, input logic c);
    id_req   = id;
    ex_req   = ex;
    mem_req  = mem;
    exc_req  = exc;
    exc_addr = addr;
    clr      = c;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    id_req   = 1'b1;
    ex_req   = 1'b0;
    mem_req  = 1'b1;
    exc_req  = 1'b1;
    exc_addr = 32'hAAAA5555;
    clr      = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    chk("rst_stall",  {26'd0, stall}, 32'd0);
    chk("rst_flush",  {31'd0, flush}, 32'd0);
    chk("rst_addr",   flush_address, 32'h0);
    chk("rst_count",  {16'd0, stall_count}, 32'd0);
    id_req = 1'b0; mem_req = 1'b0; exc_req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    cyc(0, 0, 0, 0, 32'h0, 0);

    // Priority encoding and counting.
    id_req = 1'b1; ex_req = 1'b1; #1;
    chk("prio_id_ex", {26'd0, stall}, 32'h0000000F);
    @(posedge clock); #1;
    cyc(1, 0, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 0, 32'h0, 0);
    chk("count_two", {16'd0, stall_count}, 32'd2);
    cyc(1, 1, 1, 0, 32'h0, 0);

    // Exception without memory stall; stall requests ignored in FLUSH/RECOVER.
    cyc(0, 0, 0, 1, 32'h80000080, 0);
    id_req = 1'b1; exc_req = 1'b0; #1;
    chk("exc_flush", {31'd0, flush}, 32'd1);
    chk("exc_addr",  flush_address, 32'h80000080);
    chk("exc_stall", {26'd0, stall}, 32'd0);
    @(posedge clock); #1;
    chk("recover_flush", {31'd0, flush}, 32'd0);
    chk("recover_stall", {26'd0, stall}, 32'd0);
    @(posedge clock); #1;
    chk("run_again", {26'd0, stall}, 32'h00000007);
    cyc(0, 0, 0, 0, 32'h0, 0);

    // Exception deferred by memory stall, then held through RECOVER.
    repeat (5) cyc(0, 0, 1, 1, 32'h12345678, 0);
    chk("deferred_noflush", {31'd0, flush}, 32'd0);
    cyc(0, 0, 0, 1, 32'h12345678, 0);
    chk("deferred_flush", {31'd0, flush}, 32'd1);
    chk("deferred_addr",  flush_address, 32'h12345678);
    cyc(0, 0, 0, 1, 32'h12345678, 0);
    cyc(0, 0, 0, 1, 32'h12345678, 0);
    chk("recover_not_taken", {31'd0, flush}, 32'd0);
    cyc(0, 0, 0, 1, 32'h12345678, 0);
    chk("retaken_flush", {31'd0, flush}, 32'd1);
    repeat (3) cyc(0, 0, 0, 0, 32'h0, 0);

    // A gap in the memory stall restarts the timeout.
    repeat (6) cyc(0, 0, 1, 0, 32'h0, 0);
    cyc(0, 0, 0, 0, 32'h0, 0);
    repeat (6) cyc(0, 0, 1, 0, 32'h0, 0);
    chk("gap_no_timeout", {31'd0, flush}, 32'd0);
    cyc(0, 0, 0, 0, 32'h0, 0);

    // Memory timeout.
    repeat (8) cyc(0, 0, 1, 0, 32'h0, 0);
    chk("tmo_flush", {31'd0, flush}, 32'd1);
    chk("tmo_berr",  {31'd0, bus_error}, 32'd1);
    chk("tmo_addr",  flush_address, 32'h00000180);
    cyc(0, 0, 1, 0, 32'h0, 0);
    chk("tmo_berr_pulse", {31'd0, bus_error}, 32'd0);
    repeat (2) cyc(0, 0, 0, 0, 32'h0, 0);

    // Timeout and exception on the same edge: timeout wins.
    repeat (7) cyc(0, 0, 1, 0, 32'h0, 0);
    cyc(0, 0, 1, 1, 32'hDEADBEEF, 0);
    chk("tmo_wins_addr", flush_address, 32'h00000180);
    chk("tmo_wins_berr", {31'd0, bus_error}, 32'd1);
    repeat (3) cyc(0, 0, 0, 0, 32'h0, 0);

    // Asynchronous reset during a bus-error flush.
    repeat (8) cyc(0, 0, 1, 0, 32'h0, 0);
    #1;
    chk("pre_rst_berr", {31'd0, bus_error}, 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_flush", {31'd0, flush}, 32'd0);
    chk("arst_berr",  {31'd0, bus_error}, 32'd0);
    chk("arst_stall", {26'd0, stall}, 32'd0);
    chk("arst_addr",  flush_address, 32'h0);
    mem_req = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    cyc(1, 0, 0, 0, 32'h0, 0);
    chk("post_rst_count", {16'd0, stall_count}, 32'd1);
    cyc(0, 0, 0, 0, 32'h0, 0);

    // Saturation and clear priority.
    repeat (65540) cyc(0, 1, 0, 0, 32'h0, 0);
    chk("sat_count", {16'd0, stall_count}, 32'h0000FFFF);
    cyc(0, 1, 0, 0, 32'h0, 1);
    chk("clr_count", {16'd0, stall_count}, 32'd0);
    cyc(0, 1, 0, 0, 32'h0, 0);
    chk("after_clr_count", {16'd0, stall_count}, 32'd1);
    cyc(0, 0, 0, 0, 32'h0, 0);

    @(posedge clock); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256: consecutive mem_stall_request cycles (range 2..65535) before a bus-error flush.
REQ-002 Parameter BUS_ERROR_VECTOR, default 32'h00000180: flush_address used on bus-error flush.
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 id_stall_request  input  1  load-use hazard from decode.
REQ-006 ex_stall_request  input  1  multi-cycle execute op busy.
REQ-007 mem_stall_request  input  1  memory access not yet complete.
REQ-008 exception_request  input  1  exception raised in MEM stage, level.
REQ-009 exception_handler_address  input  32  handler PC for exception_request.
REQ-010 counter_clear  input  1  synchronous clear of stall_count.
REQ-011 stall  output  6  hold per latch: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB; combinational from state and requests.
REQ-012 flush  output  1  registered; clears every pipeline latch.
REQ-013 flush_address  output  32  registered; PC loaded when flush=1.
REQ-014 bus_error  output  1  registered one-cycle pulse on memory timeout.
REQ-015 stall_count  output  16  registered, saturating count of stalled cycles.

Function
REQ-016 FSM states RUN, FLUSH, RECOVER; FLUSH and RECOVER last exactly one cycle each.
REQ-017 In RUN stall encoding, priority mem > ex > id: mem -> 6'b011111, ex -> 6'b001111, id -> 6'b000111, none -> 6'b000000.
REQ-018 In FLUSH and RECOVER stall = 6'b000000 and all stall requests are ignored.
REQ-019 RUN -> FLUSH when exception_request=1 and mem_stall_request=0 at an edge; flush_address <= exception_handler_address at that edge.
REQ-020 exception_request with mem_stall_request=1 is deferred: mem stall encoding applies until mem_stall_request falls, then REQ-019 applies if exception_request still 1.
REQ-021 Timeout counter increments each RUN cycle with mem_stall_request=1, clears on any cycle with mem_stall_request=0 or state != RUN.
REQ-022 At the edge where counter reaches TIMEOUT_CYCLES-1 with mem_stall_request=1: enter FLUSH, flush_address <= BUS_ERROR_VECTOR, bus_error=1 for that FLUSH cycle, counter clears.
REQ-023 Timeout and exception on same edge: timeout wins (exception is gated by mem stall per REQ-020).
REQ-024 flush = 1 exactly during FLUSH state; flush_address holds its value until the next flush entry.
REQ-025 FLUSH -> RECOVER -> RUN unconditionally; exception_request still high in RECOVER is not accepted until the following RUN edge (handler must lower it).
REQ-026 stall_count increments by 1 each cycle stall != 0, saturates at 16'hFFFF; counter_clear=1 forces 0 and takes priority over increment.

Reset
REQ-027 While reset=0: state RUN, flush=0, bus_error=0, flush_address=32'h0, stall_count=0, timeout counter=0, stall=6'b000000 regardless of requests.
REQ-028 Reset asserted mid-FLUSH or mid-timeout aborts immediately; first edge after release operates from RUN.

Verification
REQ-029 id=1, ex=1 same cycle -> stall=6'b001111; drop ex -> 6'b000111; drop id -> 0; stall_count=2 after.
REQ-030 exception_request=1, address 32'h80000080, no stall -> next cycle flush=1, flush_address=32'h80000080, stall=0; then one RECOVER cycle; RUN.
REQ-031 exception_request=1 with mem_stall_request=1 for 5 cycles -> stall=6'b011111 for 5 cycles, flush=1 on cycle after mem stall drops.
REQ-032 TIMEOUT_CYCLES=8, mem_stall_request held high -> after 8 stalled cycles flush=1, bus_error=1, flush_address=32'h00000180, both for one cycle.
REQ-033 stall_count preloaded near 16'hFFFF by long stall -> holds 16'hFFFF; counter_clear=1 during stall -> reads 0 next cycle.
REQ-034 reset=0 asserted asynchronously during FLUSH -> flush and bus_error drop without a clock edge; stall=0.
